// File: rtl/ubx_pkg.sv
// Shared constants, FSM states and checksum helper
// for the UBX frame parser.
package ubx_pkg;

  localparam logic [7:0] SYNC1_B = 8'hB5;
  localparam logic [7:0] SYNC2_B = 8'h62;
  localparam int G_MAX_PYL_DEF = 256;

  typedef enum logic [3:0] {
    S_SYNC1, S_SYNC2, S_CLASS, S_ID,
    S_LEN_L, S_LEN_H, S_PYL, S_CKA, S_CKB
  } state_e;

  typedef enum logic [1:0] {
    B_FREE, B_WR, B_FULL, B_RD
  } bank_e;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
  } ck_t;

  function automatic ck_t ck_upd(
    input ck_t c,
    input logic [7:0] d
  );
    ck_t r;
    r.a = c.a + d;
    r.b = c.b + r.a;
    return r;
  endfunction

endpackage

// File: rtl/ubx_frame_parser_if.sv
// Byte-in / frame-out bundle of the UBX parser.
// master = byte source side, slave = parser side.
interface ubx_frame_parser_if;
  logic [7:0]  i_data_tdata;
  logic        i_data_tvalid;
  logic [15:0] o_csid_tdata;
  logic [15:0] o_length_tdata;
  logic [7:0]  o_pyl_tdata;
  logic        o_pkt_tvalid;
  logic        o_pkt_tlast;
  logic        o_err_tvalid;

  modport master (
    output i_data_tdata, i_data_tvalid,
    input  o_csid_tdata, o_length_tdata,
    input  o_pyl_tdata, o_pkt_tvalid,
    input  o_pkt_tlast, o_err_tvalid
  );

  modport slave (
    input  i_data_tdata, i_data_tvalid,
    output o_csid_tdata, o_length_tdata,
    output o_pyl_tdata, o_pkt_tvalid,
    output o_pkt_tlast, o_err_tvalid
  );
endinterface

// File: rtl/ubx_pyl_buffer.sv
// Two-bank payload RAM with per-bank ownership
// state and completion-order selection.
module ubx_pyl_buffer
  import ubx_pkg::*;
#(
  parameter int G_MAX_PYL = G_MAX_PYL_DEF,
  parameter int G_ADDR_W  = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                we_i,
  input  logic                wbank_i,
  input  logic [G_ADDR_W-1:0] waddr_i,
  input  logic [7:0]          wdata_i,
  input  logic                claim_i,
  input  logic                commit_i,
  input  logic                abort_i,
  input  logic [15:0]         csid_i,
  input  logic [15:0]         len_i,
  input  logic                rd_start_i,
  input  logic                re_i,
  input  logic                rzero_i,
  input  logic                rbank_i,
  input  logic [G_ADDR_W-1:0] raddr_i,
  input  logic                release_i,
  output logic [7:0]          rdata_o,
  output logic [1:0]          free_o,
  output logic                rdy_o,
  output logic                pick_o,
  output logic [15:0]         csid_o,
  output logic [15:0]         len_o
);

  logic [7:0] mem [2][G_MAX_PYL];
  bank_e bank_q [2];
  logic [1:0][15:0] csid_q;
  logic [1:0][15:0] len_q;
  logic old_q;
  logic [7:0] rdata_q;
  logic [1:0] full;

  always_ff @(posedge clk) begin
    if (we_i) mem[wbank_i][waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= rzero_i ? 8'h00 : mem[rbank_i][raddr_i];
    end
  end

  // Writer and reader always touch different banks,
  // so their updates never collide on one entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_q[0] <= B_FREE;
      bank_q[1] <= B_FREE;
      csid_q <= '0;
      len_q <= '0;
      old_q <= 1'b0;
    end else begin
      if (claim_i) bank_q[wbank_i] <= B_WR;
      if (abort_i) bank_q[wbank_i] <= B_FREE;
      if (commit_i) begin
        bank_q[wbank_i] <= B_FULL;
        csid_q[wbank_i] <= csid_i;
        len_q[wbank_i] <= len_i;
        old_q <= full[~wbank_i] ? ~wbank_i : wbank_i;
      end
      if (rd_start_i) bank_q[pick_o] <= B_RD;
      if (release_i) bank_q[rbank_i] <= B_FREE;
    end
  end

  always_comb begin
    full[0] = (bank_q[0] == B_FULL);
    full[1] = (bank_q[1] == B_FULL);
    free_o[0] = (bank_q[0] == B_FREE);
    free_o[1] = (bank_q[1] == B_FREE);
    rdy_o = |full;
    pick_o = (&full) ? old_q : full[1];
    csid_o = csid_q[pick_o];
    len_o = len_q[pick_o];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/ubx_frame_parser.sv
// UBX frame parser: sync/header FSM, Fletcher check,
// ping-pong payload buffer and frame emitter.
module ubx_frame_parser
  import ubx_pkg::*;
#(
  parameter int G_MAX_PYL = G_MAX_PYL_DEF,
  parameter int G_ADDR_W  = 8
) (
  input  logic i_uart_clk,
  input  logic i_reset_n,
  ubx_frame_parser_if.slave bus
);

  localparam logic [15:0] MAX_LEN = 16'(G_MAX_PYL);

  state_e state_q, state_d;
  logic [7:0] cls_q, cls_d, id_q, id_d;
  logic [15:0] len_q, len_d, cnt_q, cnt_d;
  ck_t ck_q, ck_d;
  logic cka_ok_q, cka_ok_d;
  logic wbank_q, wbank_d;
  logic err_q, err_d;
  logic we, claim, commit, abort;
  logic [15:0] len_x;
  logic [7:0] b;

  logic rd_act_q, rbank_q, rel_q;
  logic [15:0] raddr_q, rlen_q;
  logic tvalid_q, tlast_q;
  logic [15:0] csid_out_q, len_out_q;
  logic rd_start, rd_last;
  logic [1:0] free;
  logic rdy, pick;
  logic [15:0] b_csid, b_len;
  logic [7:0] rdata;

  assign b = bus.i_data_tdata;
  assign len_x = {b, len_q[7:0]};

  always_ff @(posedge i_uart_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= S_SYNC1;
      cls_q <= '0;
      id_q <= '0;
      len_q <= '0;
      cnt_q <= '0;
      ck_q <= '0;
      cka_ok_q <= 1'b0;
      wbank_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cls_q <= cls_d;
      id_q <= id_d;
      len_q <= len_d;
      cnt_q <= cnt_d;
      ck_q <= ck_d;
      cka_ok_q <= cka_ok_d;
      wbank_q <= wbank_d;
      err_q <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cls_d = cls_q;
    id_d = id_q;
    len_d = len_q;
    cnt_d = cnt_q;
    ck_d = ck_q;
    cka_ok_d = cka_ok_q;
    wbank_d = wbank_q;
    err_d = 1'b0;
    we = 1'b0;
    claim = 1'b0;
    commit = 1'b0;
    abort = 1'b0;
    if (bus.i_data_tvalid) begin
      unique case (state_q)
        S_SYNC1: if (b == SYNC1_B) state_d = S_SYNC2;
        S_SYNC2: begin
          if (b == SYNC2_B) state_d = S_CLASS;
          else if (b != SYNC1_B) state_d = S_SYNC1;
        end
        S_CLASS: begin
          cls_d = b;
          ck_d = ck_upd('0, b);
          state_d = S_ID;
        end
        S_ID: begin
          id_d = b;
          ck_d = ck_upd(ck_q, b);
          state_d = S_LEN_L;
        end
        S_LEN_L: begin
          len_d[7:0] = b;
          ck_d = ck_upd(ck_q, b);
          state_d = S_LEN_H;
        end
        S_LEN_H: begin
          len_d = len_x;
          ck_d = ck_upd(ck_q, b);
          cnt_d = '0;
          if (len_x > MAX_LEN || free == 2'b00) begin
            err_d = 1'b1;
            state_d = S_SYNC1;
          end else begin
            claim = 1'b1;
            wbank_d = ~free[0];
            state_d = (len_x == 16'd0) ? S_CKA : S_PYL;
          end
        end
        S_PYL: begin
          we = 1'b1;
          ck_d = ck_upd(ck_q, b);
          cnt_d = cnt_q + 16'd1;
          if (cnt_q + 16'd1 == len_q) state_d = S_CKA;
        end
        S_CKA: begin
          cka_ok_d = (b == ck_q.a);
          state_d = S_CKB;
        end
        S_CKB: begin
          if (cka_ok_q && b == ck_q.b) begin
            commit = 1'b1;
          end else begin
            abort = 1'b1;
            err_d = 1'b1;
          end
          state_d = S_SYNC1;
        end
        default: state_d = S_SYNC1;
      endcase
    end
  end

  // A zero-length frame still emits one (zero) beat.
  assign rd_start = !rd_act_q && rdy;
  assign rd_last = (rlen_q == 16'd0) ||
                   (raddr_q + 16'd1 == rlen_q);

  always_ff @(posedge i_uart_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      rd_act_q <= 1'b0;
      rbank_q <= 1'b0;
      rel_q <= 1'b0;
      raddr_q <= '0;
      rlen_q <= '0;
      tvalid_q <= 1'b0;
      tlast_q <= 1'b0;
      csid_out_q <= '0;
      len_out_q <= '0;
    end else begin
      rel_q <= 1'b0;
      tvalid_q <= 1'b0;
      tlast_q <= 1'b0;
      if (rd_start) begin
        rd_act_q <= 1'b1;
        rbank_q <= pick;
        raddr_q <= '0;
        rlen_q <= b_len;
        csid_out_q <= b_csid;
        len_out_q <= b_len;
      end else if (rd_act_q) begin
        tvalid_q <= 1'b1;
        tlast_q <= rd_last;
        raddr_q <= raddr_q + 16'd1;
        if (rd_last) begin
          rd_act_q <= 1'b0;
          rel_q <= 1'b1;
        end
      end
    end
  end

  ubx_pyl_buffer #(
    .G_MAX_PYL (G_MAX_PYL),
    .G_ADDR_W  (G_ADDR_W)
  ) u_buf (
    .clk        (i_uart_clk),
    .rst_n      (i_reset_n),
    .we_i       (we),
    .wbank_i    (wbank_d),
    .waddr_i    (cnt_q[G_ADDR_W-1:0]),
    .wdata_i    (b),
    .claim_i    (claim),
    .commit_i   (commit),
    .abort_i    (abort),
    .csid_i     ({cls_q, id_q}),
    .len_i      (len_q),
    .rd_start_i (rd_start),
    .re_i       (rd_act_q),
    .rzero_i    (rlen_q == 16'd0),
    .rbank_i    (rbank_q),
    .raddr_i    (raddr_q[G_ADDR_W-1:0]),
    .release_i  (rel_q),
    .rdata_o    (rdata),
    .free_o     (free),
    .rdy_o      (rdy),
    .pick_o     (pick),
    .csid_o     (b_csid),
    .len_o      (b_len)
  );

  assign bus.o_csid_tdata = csid_out_q;
  assign bus.o_length_tdata = len_out_q;
  assign bus.o_pyl_tdata = rdata;
  assign bus.o_pkt_tvalid = tvalid_q;
  assign bus.o_pkt_tlast = tlast_q;
  assign bus.o_err_tvalid = err_q;

endmodule

// File: tb/tb_ubx_frame_parser.sv
// Directed bench for ubx_frame_parser: drives byte
// streams and checks emitted beats and error pulses.
module tb_ubx_frame_parser;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ubx_frame_parser_if bus ();

  ubx_frame_parser #(
    .G_MAX_PYL (256),
    .G_ADDR_W  (8)
  ) dut (
    .i_uart_clk (clk),
    .i_reset_n  (rst_n),
    .bus        (bus)
  );

  typedef struct {
    logic [7:0]  d;
    logic        l;
    logic [15:0] c;
    logic [15:0] n;
    int unsigned cy;
  } beat_t;

  beat_t beats[$];
  logic [7:0] tx_q[$];
  logic [7:0] exp_q[$];
  int errs = 0;
  int checks = 0;
  int fails = 0;
  int unsigned cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.o_pkt_tvalid)
      beats.push_back('{bus.o_pyl_tdata, bus.o_pkt_tlast,
                        bus.o_csid_tdata, bus.o_length_tdata, cyc});
    if (bus.o_err_tvalid) errs++;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, "_csid"}, 32'(bus.o_csid_tdata), 0);
    chk({tag, "_len"}, 32'(bus.o_length_tdata), 0);
    chk({tag, "_pyl"}, 32'(bus.o_pyl_tdata), 0);
    chk({tag, "_tv"}, 32'(bus.o_pkt_tvalid), 0);
    chk({tag, "_tl"}, 32'(bus.o_pkt_tlast), 0);
    chk({tag, "_err"}, 32'(bus.o_err_tvalid), 0);
  endtask

  task automatic send();
    foreach (tx_q[i]) begin
      @(negedge clk);
      bus.i_data_tdata = tx_q[i];
      bus.i_data_tvalid = 1'b1;
    end
    tx_q.delete();
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    bus.i_data_tvalid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic clr();
    beats.delete();
    exp_q.delete();
    errs = 0;
  endtask

  // Appends one frame to tx_q and its payload to exp_q.
  task automatic build(input logic [7:0] cls,
                       input logic [7:0] id,
                       input int len,
                       input logic [7:0] first,
                       input logic [7:0] bad);
    logic [7:0] a, b2, v;
    logic [7:0] hdr[4];
    a = 0;
    b2 = 0;
    hdr[0] = cls;
    hdr[1] = id;
    hdr[2] = 8'(len);
    hdr[3] = 8'(len >> 8);
    tx_q.push_back(8'hB5);
    tx_q.push_back(8'h62);
    for (int i = 0; i < 4; i++) begin
      tx_q.push_back(hdr[i]);
      a = a + hdr[i];
      b2 = b2 + a;
    end
    for (int i = 0; i < len; i++) begin
      v = first + 8'(i);
      tx_q.push_back(v);
      exp_q.push_back(v);
      a = a + v;
      b2 = b2 + a;
    end
    tx_q.push_back(a);
    tx_q.push_back(b2 ^ bad);
  endtask

  task automatic chk_frame(input string tag, input int base,
                           input logic [15:0] csid,
                           input logic [15:0] len,
                           input int eoff);
    int n;
    n = (len == 0) ? 1 : int'(len);
    for (int i = 0; i < n; i++) begin
      if (base + i < beats.size()) begin
        chk($sformatf("%s_d%0d", tag, i), 32'(beats[base+i].d),
            (len == 0) ? 32'd0 : 32'(exp_q[eoff+i]));
        chk($sformatf("%s_l%0d", tag, i), 32'(beats[base+i].l),
            32'(i == n - 1));
        chk($sformatf("%s_c%0d", tag, i), 32'(beats[base+i].c),
            32'(csid));
        chk($sformatf("%s_n%0d", tag, i), 32'(beats[base+i].n),
            32'(len));
        if (i > 0)
          chk($sformatf("%s_gap%0d", tag, i), beats[base+i].cy,
              beats[base+i-1].cy + 1);
      end
    end
  endtask

  task automatic frame1();
    tx_q.push_back(8'hB5); tx_q.push_back(8'h62);
    tx_q.push_back(8'h01); tx_q.push_back(8'h02);
    tx_q.push_back(8'h04); tx_q.push_back(8'h00);
    tx_q.push_back(8'hAA); tx_q.push_back(8'hBB);
    tx_q.push_back(8'hCC); tx_q.push_back(8'hDD);
    tx_q.push_back(8'h15); tx_q.push_back(8'h7C);
  endtask

  task automatic exp1();
    exp_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    bus.i_data_tdata = 8'h00;
    bus.i_data_tvalid = 1'b0;
    repeat (3) @(negedge clk);
    chk_rst("reset");
    rst_n = 1'b1;
    idle(2);

    clr(); frame1(); exp1(); send(); idle(30);
    chk("f1_nbeats", beats.size(), 4);
    chk_frame("f1", 0, 16'h0102, 16'd4, 0);
    chk("f1_err", errs, 0);

    clr();
    tx_q = '{8'hB5, 8'h62, 8'h0A, 8'h04, 8'h00, 8'h00, 8'h0E, 8'h34};
    send(); idle(20);
    chk("poll_nbeats", beats.size(), 1);
    chk_frame("poll", 0, 16'h0A04, 16'd0, 0);
    chk("poll_err", errs, 0);

    clr(); frame1(); tx_q[11] = 8'h7D; send(); idle(30);
    chk("bad_err", errs, 1);
    chk("bad_nbeats", beats.size(), 0);
    clr(); frame1(); exp1(); send(); idle(30);
    chk("after_bad_n", beats.size(), 4);
    chk_frame("after_bad", 0, 16'h0102, 16'd4, 0);

    clr();
    tx_q = '{8'h00, 8'hB5};
    frame1();
    exp1(); send(); idle(30);
    chk("resync_n", beats.size(), 4);
    chk_frame("resync", 0, 16'h0102, 16'd4, 0);
    clr();
    tx_q = '{8'hB5, 8'h00, 8'h62};
    send(); idle(20);
    chk("nosync_n", beats.size(), 0);
    chk("nosync_err", errs, 0);

    clr();
    tx_q = '{8'hB5, 8'h62, 8'h01, 8'h02, 8'h01, 8'h01};
    frame1(); exp1(); send(); idle(30);
    chk("oversize_err", errs, 1);
    chk("oversize_n", beats.size(), 4);
    chk_frame("oversize", 0, 16'h0102, 16'd4, 0);

    clr();
    build(8'h10, 8'h01, 4, 8'h10, 8'h00);
    build(8'h10, 8'h02, 4, 8'h20, 8'h00);
    build(8'h10, 8'h03, 4, 8'h30, 8'h00);
    send(); idle(40);
    chk("b2b_n", beats.size(), 12);
    chk("b2b_err", errs, 0);
    chk_frame("b2b0", 0, 16'h1001, 16'd4, 0);
    chk_frame("b2b1", 4, 16'h1002, 16'd4, 4);
    chk_frame("b2b2", 8, 16'h1003, 16'd4, 8);

    clr();
    build(8'h20, 8'h01, 16, 8'h40, 8'h00);
    build(8'h20, 8'h02, 0, 8'h00, 8'h00);
    build(8'h20, 8'h03, 0, 8'h00, 8'h00);
    send(); idle(50);
    chk("busy_err", errs, 1);
    chk("busy_n", beats.size(), 17);
    chk_frame("busyA", 0, 16'h2001, 16'd16, 0);
    chk_frame("busyB", 16, 16'h2002, 16'd0, 0);
    clr(); frame1(); exp1(); send(); idle(30);
    chk("busy_after_n", beats.size(), 4);
    chk_frame("busy_after", 0, 16'h0102, 16'd4, 0);

    clr();
    build(8'h30, 8'h01, 16, 8'h80, 8'h00);
    tx_q.push_back(8'hB5); tx_q.push_back(8'h62);
    tx_q.push_back(8'h01); tx_q.push_back(8'h02);
    tx_q.push_back(8'h04); tx_q.push_back(8'h00);
    tx_q.push_back(8'hAA);
    send();
    @(negedge clk);
    chk("rst_mid_emit", 32'(beats.size() > 0), 1);
    rst_n = 1'b0;
    bus.i_data_tvalid = 1'b0;
    #2;
    chk_rst("rst_mid");
    repeat (3) @(negedge clk);
    chk_rst("rst_hold");
    clr();
    rst_n = 1'b1;
    idle(2);
    chk("rst_noleak", beats.size(), 0);
    frame1(); exp1(); send(); idle(30);
    chk("post_rst_n", beats.size(), 4);
    chk_frame("post_rst", 0, 16'h0102, 16'd4, 0);
    chk("post_rst_err", errs, 0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
